// File: rtl/otter_iobus_responder_if.sv
// OTTER IOBUS signal bundle: the CPU drives address, write data and strobe;
// the responder returns combinational read data.
interface otter_iobus_responder_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input  IOBUS_IN);
  modport slave  (input  IOBUS_ADDR, input  IOBUS_OUT, input  IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/otter_iobus_responder.sv
// Memory-mapped I/O responder for the OTTER IOBUS: switches, buttons with edge capture,
// LED/seven-segment registers, and an optional countdown timer (macro IOBUS_TIMER_EN).
module otter_iobus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          N_SW        = 16,
  parameter int          N_BTN       = 5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  otter_iobus_responder_if.slave    bus,
  input  logic [N_SW-1:0]           SWITCHES,
  input  logic [N_BTN-1:0]          BUTTONS,
  output logic [15:0]               LEDS,
  output logic [15:0]               SSEG,
  output logic                      IRQ
);

  localparam logic [4:0] OFF_SW        = 5'h00;
  localparam logic [4:0] OFF_BTN       = 5'h01;
  localparam logic [4:0] OFF_BTN_EDGE  = 5'h02;
  localparam logic [4:0] OFF_BTN_IE    = 5'h03;
  localparam logic [4:0] OFF_LEDS      = 5'h08;
  localparam logic [4:0] OFF_SSEG      = 5'h10;
  localparam logic [4:0] OFF_TMR_LOAD  = 5'h18;
  localparam logic [4:0] OFF_TMR_CTRL  = 5'h19;
  localparam logic [4:0] OFF_TMR_COUNT = 5'h1A;
  localparam logic [4:0] OFF_TMR_STAT  = 5'h1B;

  // Address decode: 128-byte window, word-granular.
  logic       in_window;
  logic [4:0] word;
  logic       wr_hit;

  assign in_window = (bus.IOBUS_ADDR[31:7] == BASE_ADDR[31:7]);
  assign word      = bus.IOBUS_ADDR[6:2];
  assign wr_hit    = bus.IOBUS_WR && in_window;

  logic unused_bits;
  assign unused_bits = ^{bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT[31:16]};

  // Input synchronizers; the last stage is the architecturally visible value.
  logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_sync;
  logic [SYNC_STAGES-1:0][N_BTN-1:0] btn_sync;
  logic [N_SW-1:0]                   sw_q;
  logic [N_BTN-1:0]                  btn_q;
  logic [N_BTN-1:0]                  btn_prev;
  logic [N_BTN-1:0]                  btn_edge;
  logic [N_BTN-1:0]                  btn_ie;
  logic [N_BTN-1:0]                  btn_rise;
  logic [N_BTN-1:0]                  btn_edge_clr;

  assign sw_q         = sw_sync[SYNC_STAGES-1];
  assign btn_q        = btn_sync[SYNC_STAGES-1];
  assign btn_rise     = btn_q & ~btn_prev;
  assign btn_edge_clr = (wr_hit && word == OFF_BTN_EDGE) ? bus.IOBUS_OUT[N_BTN-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the synchronizer chains are reset too, so SW/BTN read a known 0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_sync  <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      btn_edge <= '0;
      btn_ie   <= '0;
      LEDS     <= '0;
      SSEG     <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], SWITCHES};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], BUTTONS};
      btn_prev <= btn_q;
      // A new rising edge beats a simultaneous write-1-to-clear.
      btn_edge <= (btn_edge & ~btn_edge_clr) | btn_rise;
      if (wr_hit && word == OFF_BTN_IE) btn_ie <= bus.IOBUS_OUT[N_BTN-1:0];
      if (wr_hit && word == OFF_LEDS)   LEDS   <= bus.IOBUS_OUT[15:0];
      if (wr_hit && word == OFF_SSEG)   SSEG   <= bus.IOBUS_OUT[15:0];
    end
  end

  logic exp_irq;

`ifdef IOBUS_TIMER_EN
  typedef enum logic {TMR_IDLE = 1'b0, TMR_RUN = 1'b1} tmr_state_t;

  tmr_state_t  tmr_state, tmr_state_nxt;
  logic [31:0] tmr_load;
  logic [31:0] tmr_count, tmr_count_nxt;
  logic        tmr_ar, tmr_ie, tmr_exp, tmr_exp_set;
  logic        ctrl_wr;
  logic        stat_clr;

  assign ctrl_wr  = wr_hit && word == OFF_TMR_CTRL;
  assign stat_clr = wr_hit && word == OFF_TMR_STAT && bus.IOBUS_OUT[0];

  always_ff @(posedge CLK) begin
    if (RST) tmr_state <= TMR_IDLE;
    else     tmr_state <= tmr_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    tmr_state_nxt = tmr_state;
    tmr_count_nxt = tmr_count;
    tmr_exp_set   = 1'b0;
    case (tmr_state)
      TMR_IDLE: ;
      TMR_RUN: begin
        if (tmr_count == 32'd0) begin
          tmr_exp_set = 1'b1;
          if (tmr_ar) tmr_count_nxt = tmr_load;
          else        tmr_state_nxt = TMR_IDLE;
        end else begin
          tmr_count_nxt = tmr_count - 32'd1;
        end
      end
      default: tmr_state_nxt = TMR_IDLE;
    endcase
    // A CTRL write overrides counting: EN=1 (re)starts, EN=0 freezes the count.
    if (ctrl_wr) begin
      if (bus.IOBUS_OUT[0]) begin
        tmr_state_nxt = TMR_RUN;
        tmr_count_nxt = tmr_load;
      end else begin
        tmr_state_nxt = TMR_IDLE;
        tmr_count_nxt = tmr_count;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr_load  <= '0;
      tmr_count <= '0;
      tmr_ar    <= 1'b0;
      tmr_ie    <= 1'b0;
      tmr_exp   <= 1'b0;
    end else begin
      if (wr_hit && word == OFF_TMR_LOAD) tmr_load <= bus.IOBUS_OUT;
      if (ctrl_wr) begin
        tmr_ar <= bus.IOBUS_OUT[1];
        tmr_ie <= bus.IOBUS_OUT[2];
      end
      tmr_count <= tmr_count_nxt;
      tmr_exp   <= (tmr_exp & ~stat_clr) | tmr_exp_set;
    end
  end

  assign exp_irq = tmr_exp & tmr_ie;
`else
  assign exp_irq = 1'b0;
`endif

  // Reads are side-effect free; EN reads back as the RUN state.
  always_comb begin
    bus.IOBUS_IN = 32'd0;
    if (in_window) begin
      case (word)
        OFF_SW:        bus.IOBUS_IN = 32'(sw_q);
        OFF_BTN:       bus.IOBUS_IN = 32'(btn_q);
        OFF_BTN_EDGE:  bus.IOBUS_IN = 32'(btn_edge);
        OFF_BTN_IE:    bus.IOBUS_IN = 32'(btn_ie);
        OFF_LEDS:      bus.IOBUS_IN = {16'd0, LEDS};
        OFF_SSEG:      bus.IOBUS_IN = {16'd0, SSEG};
`ifdef IOBUS_TIMER_EN
        OFF_TMR_LOAD:  bus.IOBUS_IN = tmr_load;
        OFF_TMR_CTRL:  bus.IOBUS_IN = {29'd0, tmr_ie, tmr_ar, tmr_state == TMR_RUN};
        OFF_TMR_COUNT: bus.IOBUS_IN = tmr_count;
        OFF_TMR_STAT:  bus.IOBUS_IN = {31'd0, tmr_exp};
`endif
        default:       bus.IOBUS_IN = 32'd0;
      endcase
    end
  end

  assign IRQ = exp_irq | (|(btn_edge & btn_ie));

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Directed self-checking bench for otter_iobus_responder; timer checks follow
// the IOBUS_TIMER_EN build option.
module tb_otter_iobus_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] SWITCHES;
  logic [4:0]  BUTTONS;
  logic [15:0] LEDS;
  logic [15:0] SSEG;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  otter_iobus_responder_if bus ();

  otter_iobus_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus.slave),
    .SWITCHES (SWITCHES),
    .BUTTONS  (BUTTONS),
    .LEDS     (LEDS),
    .SSEG     (SSEG),
    .IRQ      (IRQ)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    tick();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.IOBUS_ADDR = addr;
    #1;
    check(tag, bus.IOBUS_IN, exp);
  endtask

  initial begin
    RST = 1'b1;
    SWITCHES = '0;
    BUTTONS  = '0;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    tick(); tick(); tick();
    RST = 1'b0;
    tick();

    // Reset state: whole window reads 0, outputs idle.
    for (int off = 0; off <= 32'h6C; off += 4)
      chk_rd($sformatf("rst_rd_%02h", off), BASE + 32'(off), 32'd0);
    check("rst_leds", {16'd0, LEDS}, 32'd0);
    check("rst_sseg", {16'd0, SSEG}, 32'd0);
    check("rst_irq",  {31'd0, IRQ},  32'd0);

    // LED / SSEG registers, upper bits dropped, unmapped writes ignored.
    wr(BASE + 32'h20, 32'hFFFF_A5A5);
    check("leds_out", {16'd0, LEDS}, 32'h0000_A5A5);
    chk_rd("leds_rd", BASE + 32'h20, 32'h0000_A5A5);
    wr(BASE + 32'h40, 32'h1234_5678);
    check("sseg_out", {16'd0, SSEG}, 32'h0000_5678);
    chk_rd("sseg_rd", BASE + 32'h40, 32'h0000_5678);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    check("unmap_leds", {16'd0, LEDS}, 32'h0000_A5A5);
    check("unmap_sseg", {16'd0, SSEG}, 32'h0000_5678);
    chk_rd("unmap_rd", BASE + 32'h10, 32'd0);
    wr(BASE + 32'h80, 32'h0000_1111);
    check("outwin_leds", {16'd0, LEDS}, 32'h0000_A5A5);
    chk_rd("outwin_rd", BASE + 32'h80, 32'd0);
    chk_rd("alias_rd", 32'h2100_0020, 32'd0);
    chk_rd("lowbits_rd", BASE + 32'h23, 32'h0000_A5A5);

    // Switch synchronizer latency.
    SWITCHES = 16'h00F0;
    chk_rd("sw_0edge", BASE, 32'd0);
    tick();
    chk_rd("sw_1edge", BASE, 32'd0);
    tick();
    chk_rd("sw_2edge", BASE, 32'h0000_00F0);

    // Button edge capture and interrupt.
    wr(BASE + 32'h0C, 32'h0000_0004);
    chk_rd("btn_ie_rd", BASE + 32'h0C, 32'h0000_0004);
    BUTTONS = 5'h04;
    tick();
    chk_rd("btn_1edge", BASE + 32'h04, 32'd0);
    tick();
    chk_rd("btn_2edge", BASE + 32'h04, 32'h0000_0004);
    chk_rd("edge_not_yet", BASE + 32'h08, 32'd0);
    check("irq_not_yet", {31'd0, IRQ}, 32'd0);
    tick();
    chk_rd("edge_set", BASE + 32'h08, 32'h0000_0004);
    check("irq_btn", {31'd0, IRQ}, 32'd1);
    BUTTONS = 5'h00;
    wr(BASE + 32'h08, 32'h0000_0004);
    chk_rd("edge_w1c", BASE + 32'h08, 32'd0);
    check("irq_w1c", {31'd0, IRQ}, 32'd0);
    tick(); tick(); tick();
    chk_rd("btn_released", BASE + 32'h04, 32'd0);

    // Set and W1C in the same cycle: the set wins.
    BUTTONS = 5'h04;
    tick(); tick();
    chk_rd("edge_pre_race", BASE + 32'h08, 32'd0);
    wr(BASE + 32'h08, 32'h0000_0004);
    chk_rd("edge_race", BASE + 32'h08, 32'h0000_0004);
    check("irq_race", {31'd0, IRQ}, 32'd1);
    BUTTONS = 5'h00;
    wr(BASE + 32'h08, 32'h0000_0004);
    chk_rd("edge_race_clr", BASE + 32'h08, 32'd0);
    tick(); tick(); tick();

`ifdef IOBUS_TIMER_EN
    // One-shot countdown from 3.
    wr(BASE + 32'h60, 32'd3);
    chk_rd("load_rd", BASE + 32'h60, 32'd3);
    wr(BASE + 32'h64, 32'h5);
    chk_rd("os_cnt3", BASE + 32'h68, 32'd3);
    chk_rd("os_ctrl_run", BASE + 32'h64, 32'h5);
    tick();
    chk_rd("os_cnt2", BASE + 32'h68, 32'd2);
    tick();
    chk_rd("os_cnt1", BASE + 32'h68, 32'd1);
    tick();
    chk_rd("os_cnt0", BASE + 32'h68, 32'd0);
    chk_rd("os_stat_pre", BASE + 32'h6C, 32'd0);
    check("os_irq_pre", {31'd0, IRQ}, 32'd0);
    tick();
    chk_rd("os_stat_exp", BASE + 32'h6C, 32'd1);
    check("os_irq_exp", {31'd0, IRQ}, 32'd1);
    chk_rd("os_ctrl_idle", BASE + 32'h64, 32'h4);
    tick();
    chk_rd("os_cnt_hold", BASE + 32'h68, 32'd0);
    wr(BASE + 32'h6C, 32'd1);
    chk_rd("os_stat_clr", BASE + 32'h6C, 32'd0);
    check("os_irq_clr", {31'd0, IRQ}, 32'd0);

    // Auto-reload with period 2, then a mid-run load change.
    wr(BASE + 32'h60, 32'd1);
    wr(BASE + 32'h64, 32'h3);
    chk_rd("ar_cnt_e0", BASE + 32'h68, 32'd1);
    tick();
    chk_rd("ar_cnt_e1", BASE + 32'h68, 32'd0);
    chk_rd("ar_stat_e1", BASE + 32'h6C, 32'd0);
    tick();
    chk_rd("ar_stat_e2", BASE + 32'h6C, 32'd1);
    chk_rd("ar_cnt_e2", BASE + 32'h68, 32'd1);
    check("ar_irq_masked", {31'd0, IRQ}, 32'd0);
    wr(BASE + 32'h6C, 32'd1);
    chk_rd("ar_stat_e3", BASE + 32'h6C, 32'd0);
    wr(BASE + 32'h6C, 32'd1);
    chk_rd("ar_stat_race", BASE + 32'h6C, 32'd1);
    chk_rd("ar_cnt_e4", BASE + 32'h68, 32'd1);
    wr(BASE + 32'h60, 32'd5);
    chk_rd("ar_cnt_e5", BASE + 32'h68, 32'd0);
    tick();
    chk_rd("ar_reload5", BASE + 32'h68, 32'd5);
    wr(BASE + 32'h6C, 32'd1);
    chk_rd("ar_cnt_e7", BASE + 32'h68, 32'd4);
    tick(); tick(); tick(); tick();
    chk_rd("ar_cnt_e11", BASE + 32'h68, 32'd0);
    chk_rd("ar_stat_e11", BASE + 32'h6C, 32'd0);
    tick();
    chk_rd("ar_stat_e12", BASE + 32'h6C, 32'd1);
    chk_rd("ar_cnt_e12", BASE + 32'h68, 32'd5);
    tick();
    chk_rd("ar_cnt_e13", BASE + 32'h68, 32'd4);

    // Reset mid-count.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_rd("rst_tmr_cnt",  BASE + 32'h68, 32'd0);
    chk_rd("rst_tmr_ctrl", BASE + 32'h64, 32'd0);
    chk_rd("rst_tmr_stat", BASE + 32'h6C, 32'd0);
    check("rst_tmr_irq", {31'd0, IRQ}, 32'd0);
`else
    // Timer absent: its offsets are inert.
    wr(BASE + 32'h64, 32'h7);
    chk_rd("notmr_ctrl", BASE + 32'h64, 32'd0);
    wr(BASE + 32'h60, 32'd5);
    chk_rd("notmr_load", BASE + 32'h60, 32'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk_rd("notmr_cnt",  BASE + 32'h68, 32'd0);
    chk_rd("notmr_stat", BASE + 32'h6C, 32'd0);
    check("notmr_irq", {31'd0, IRQ}, 32'd0);
`endif

    // Reset has priority over a same-cycle write.
    wr(BASE + 32'h20, 32'h0000_00FF);
    check("pre_rst_leds", {16'd0, LEDS}, 32'h0000_00FF);
    RST = 1'b1;
    wr(BASE + 32'h20, 32'h0000_1234);
    RST = 1'b0;
    check("rst_prio_leds", {16'd0, LEDS}, 32'd0);
    chk_rd("rst_prio_sw", BASE, 32'd0);
    chk_rd("rst_prio_ie", BASE + 32'h0C, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_iobus_responder.md
# otter_iobus_responder

Memory-mapped I/O responder on the far end of the OTTER CPU's IOBUS. Decodes IOBUS_ADDR, returns read data on IOBUS_IN, and latches CPU writes on IOBUS_WR. Provides:
- synchronized switches and buttons with edge capture;
- LED and seven-segment output registers;
- a programmable countdown timer with an interrupt request line for future trap support.

## Interface
- BASE_ADDR, 32'h1100_0000: base of the 128-byte register window.
- N_SW, 16: switch count; must be ≤ 32.
- N_BTN, 5: button count; must be ≤ 32.
- SYNC_STAGES, 2: input synchronizer depth; must be ≥ 2.

Ports:
- CLK, input, 1: system clock. All state updates on the rising edge.
- RST, input, 1: reset. Synchronous, active-high.
- IOBUS_ADDR, input, 32: byte address from the CPU. Bits [1:0] are ignored.
- IOBUS_OUT, input, 32: write data from the CPU.
- IOBUS_WR, input, 1: write strobe, one cycle per store.
- IOBUS_IN, output, 32: read data. Combinational from IOBUS_ADDR and register state.
- SWITCHES, input, N_SW: asynchronous switch inputs.
- BUTTONS, input, N_BTN: asynchronous button inputs.
- LEDS, output, 16: LED register.
- SSEG, output, 16: seven-segment display value register.
- IRQ, output, 1: level interrupt request.

## Operation
Register map. Offsets are from BASE_ADDR. Unmapped offsets and addresses outside the window read 0, and writes to them are ignored.
- 0x00 SW (RO): synchronized SWITCHES, zero-extended.
- 0x04 BTN (RO): synchronized BUTTONS, zero-extended.
- 0x08 BTN_EDGE (R/W1C): sticky rising-edge flags, one per button.
- 0x0C BTN_IE (RW): button interrupt enables, N_BTN bits.
- 0x20 LEDS (RW): bits [15:0]. Upper write bits are dropped.
- 0x40 SSEG (RW): bits [15:0]. Upper write bits are dropped.
- 0x60 TMR_LOAD (RW): 32-bit reload value.
- 0x64 TMR_CTRL (RW):
  - bit0 EN: enable.
  - bit1 AR: auto-reload.
  - bit2 IE: interrupt enable.
  - Other bits read 0.
- 0x68 TMR_COUNT (RO): current count.
- 0x6C TMR_STAT (R/W1C): bit0 EXP, expired flag.

Reads have no side effects, because the CPU provides no read strobe.

Button edge capture:
- BTN_EDGE[i] sets when the synchronized BTN[i] is 1 and its previous sample is 0.
- If a set and a write-1-to-clear land on the same bit in the same cycle, the set wins.

Timer state machine:
- States: IDLE and RUN. Reset state is IDLE.
- IDLE → RUN: on a write to TMR_CTRL with EN=1. TMR_COUNT loads TMR_LOAD on that same edge.
- RUN, count ≠ 0: count decrements by 1 each cycle.
- RUN, count = 0:
  - EXP sets.
  - If AR=1: count reloads TMR_LOAD and the timer stays in RUN. Period is TMR_LOAD+1 cycles.
  - If AR=0: the timer goes to IDLE, EN clears, and count holds at 0.
- RUN → IDLE: on a write to TMR_CTRL with EN=0. Count holds its value.
- A write of EN=1 while already in RUN restarts the count from TMR_LOAD.
- A TMR_LOAD write during RUN does not disturb the count. It takes effect at the next reload.
- If an EXP set and a write-1-to-clear land in the same cycle, the set wins.

IRQ is the combinational OR of:
- EXP & IE;
- |(BTN_EDGE & BTN_IE).

## Timing
- Reset values: all registers, synchronizer flops and the timer state are 0 or IDLE. Consequently LEDS=0, SSEG=0, IRQ=0, and IOBUS_IN=0 for every address except SW and BTN, which reflect synchronizer contents (0 after reset).
- Read latency: zero cycles. IOBUS_IN is valid in the same cycle as IOBUS_ADDR, so the memory samples it at the next edge. The value returned is register state before that edge.
- Writes commit on the edge where IOBUS_WR=1. Readback and the LEDS/SSEG outputs show the new value in the following cycle.
- A BUTTONS change becomes visible:
  - in BTN after SYNC_STAGES edges;
  - in BTN_EDGE one edge later;
  - on IRQ in the same cycle BTN_EDGE sets.
- Timer, starting from TMR_LOAD=N with AR=0: EXP reads 1 exactly N+1 edges after the enabling write edge.
- RST has priority over any write in the same cycle. A reset mid-count returns the timer to IDLE with count 0.

## Configuration
- IOBUS_TIMER_EN defined: the timer, offsets 0x60–0x6C, and the EXP term of IRQ are present.
- Undefined: no timer logic is built, offsets 0x60–0x6C read 0 and ignore writes, and IRQ = |(BTN_EDGE & BTN_IE).

## Test plan
- Reset, then read each of 0x1100_0000–0x1100_006C → all read 0; LEDS=0, SSEG=0, IRQ=0.
- Write 0xFFFF_A5A5 to 0x1100_0020 and 0x1234_5678 to 0x1100_0040 → LEDS=0xA5A5 and SSEG=0x5678 on the next cycle, with matching readback. Write to 0x1100_0010 → LEDS and SSEG unchanged, and 0x1100_0010 reads 0.
- SWITCHES=0x00F0 → SW reads 0x0000_00F0 only after 2 edges. Pulse BUTTONS[2] with BTN_IE=0x04 → BTN_EDGE=0x04 and IRQ=1. Write 0x04 to 0x08 → BTN_EDGE=0 and IRQ=0. Repeat with the W1C issued in the same cycle as a new edge → the flag stays 1.
- TMR_LOAD=3, write TMR_CTRL=0x5 → count reads 3,2,1,0; EXP=1 and IRQ=1 on the 4th edge; EN reads 0 and count holds at 0.
- TMR_LOAD=1, TMR_CTRL=0x3 → EXP re-asserts every 2 cycles. TMR_LOAD=5 written mid-run → the current period is unaffected and the next period is 6 cycles. Assert RST mid-count → count=0, TMR_CTRL=0, EXP=0.
- Build without IOBUS_TIMER_EN, write 0x7 to 0x1100_0064 → reads 0, and IRQ stays 0 with no button edges pending.
